// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants and the coordinate type shared by the VGA timing slice.
package vga_timing_pkg;
   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;
   localparam int BG_W      = 712;

   localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_VISIBLE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC - 1;
   localparam int VS_START = V_VISIBLE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC - 1;

   typedef logic [9:0] coord_t;
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus visible/sync flags decoded from the next count,
// so the flags always line up with the count presented on the same cycle.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int TOTAL      = H_TOTAL,
   parameter int VISIBLE    = H_VISIBLE,
   parameter int SYNC_START = HS_START,
   parameter int SYNC_END   = HS_END
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   inc,
   output coord_t count,
   output logic   wrap,
   output logic   visible,
   output logic   sync_n
);
   localparam coord_t LAST = coord_t'(TOTAL - 1);
   localparam coord_t VIS  = coord_t'(VISIBLE);
   localparam coord_t SS   = coord_t'(SYNC_START);
   localparam coord_t SE   = coord_t'(SYNC_END);

   coord_t count_q, count_d;
   logic   visible_q, sync_n_q;

   assign wrap = inc && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (inc) count_d = wrap ? '0 : count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         visible_q <= 1'b1;
         sync_n_q  <= 1'b1;
      end else begin
         count_q   <= count_d;
         visible_q <= (count_d < VIS);
         sync_n_q  <= !((count_d >= SS) && (count_d <= SE));
      end
   end

   assign count   = count_q;
   assign visible = visible_q;
   assign sync_n  = sync_n_q;
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: sync, visible flag, DrawX/DrawY and line/frame strobes.
// Define VGA_SCROLL_EN to add the per-frame scroll offset and the wrapped BgX column.
module vga_timing_gen
   import vga_timing_pkg::coord_t;
#(
   parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
   parameter int H_FP      = vga_timing_pkg::H_FP,
   parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int H_BP      = vga_timing_pkg::H_BP,
   parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
   parameter int V_FP      = vga_timing_pkg::V_FP,
   parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int V_BP      = vga_timing_pkg::V_BP,
   parameter int BG_W      = vga_timing_pkg::BG_W
) (
   input  logic       vga_clk,
   input  logic       reset,
`ifdef VGA_SCROLL_EN
   input  logic [9:0] scroll_x,
   output logic [9:0] BgX,
`endif
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       line_start,
   output logic       frame_start
);
   localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_VISIBLE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC - 1;
   localparam int VS_START = V_VISIBLE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC - 1;

   if (H_TOTAL > 1024 || V_TOTAL > 1024 || BG_W > 1023) begin : g_cfg_err
      $error("vga_timing_gen: timing totals exceed the 10-bit counter range");
   end

   logic h_wrap, v_wrap, h_vis, v_vis;
   logic line_start_q, frame_start_q;

   vga_axis_counter #(
      .TOTAL(H_TOTAL), .VISIBLE(H_VISIBLE), .SYNC_START(HS_START), .SYNC_END(HS_END)
   ) u_h (
      .clk(vga_clk), .reset(reset), .inc(1'b1),
      .count(DrawX), .wrap(h_wrap), .visible(h_vis), .sync_n(hs)
   );

   vga_axis_counter #(
      .TOTAL(V_TOTAL), .VISIBLE(V_VISIBLE), .SYNC_START(VS_START), .SYNC_END(VS_END)
   ) u_v (
      .clk(vga_clk), .reset(reset), .inc(h_wrap),
      .count(DrawY), .wrap(v_wrap), .visible(v_vis), .sync_n(vs)
   );

   assign blank = h_vis & v_vis;

   // Strobes come only from natural wraps, so the reset state never pulses them.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         line_start_q  <= h_wrap;
         frame_start_q <= v_wrap;
      end
   end

   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_SCROLL_EN
   localparam coord_t BG_LIM = coord_t'(BG_W);

   coord_t      x_next, scroll_q, scroll_d, bgx_q, bgx_d;
   logic [10:0] bg_sum;

   // BgX is built from next-cycle values so it lands aligned with DrawX.
   always_comb begin
      x_next   = h_wrap ? '0 : DrawX + 1'b1;
      scroll_d = scroll_q;
      if (v_wrap && (scroll_x < BG_LIM)) scroll_d = scroll_x;
      bg_sum = {1'b0, x_next} + {1'b0, scroll_d};
      bgx_d  = (bg_sum >= {1'b0, BG_LIM}) ? coord_t'(bg_sum - {1'b0, BG_LIM}) : bg_sum[9:0];
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         scroll_q <= '0;
         bgx_q    <= '0;
      end else begin
         scroll_q <= scroll_d;
         bgx_q    <= bgx_d;
      end
   end

   assign BgX = bgx_q;
`endif
endmodule
